// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and a
// multi-cycle divide stall that freezes the whole pipeline.
module pipe_hazard_ctrl #(
   parameter int DIV_CYCLES = 32
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [4:0]  id_rs_addr_i,
   input  logic [4:0]  id_rt_addr_i,
   input  logic        ex_memread_i,
   input  logic [4:0]  ex_rt_addr_i,
   input  logic        ex_branch_taken_i,
   input  logic        ex_div_start_i,
   output logic        pc_en_o,
   output logic        ifid_en_o,
   output logic        ifid_flush_o,
   output logic        idex_en_o,
   output logic        idex_flush_o,
   output logic        exmem_en_o,
   output logic        div_busy_o,
   output logic        div_done_o,
   output logic [31:0] stall_cycles_o
);

   typedef enum logic {RUN, DIV} state_t;

   // The start cycle is itself a stall cycle, so DIV only needs DIV_CYCLES-1 more.
   localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 2);

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] stall_q, stall_d;
   logic        loadUse;
   logic        divStall;

   assign loadUse  = ex_memread_i && (ex_rt_addr_i != 5'd0) &&
                     ((ex_rt_addr_i == id_rs_addr_i) || (ex_rt_addr_i == id_rt_addr_i));
   assign divStall = (state_q == DIV) || ex_div_start_i;

   // Pipeline control: divide freeze beats branch flush beats load-use bubble.
   always_comb begin
      pc_en_o      = 1'b0;
      ifid_en_o    = 1'b0;
      ifid_flush_o = 1'b0;
      idex_en_o    = 1'b0;
      idex_flush_o = 1'b0;
      exmem_en_o   = 1'b0;
      div_busy_o   = 1'b0;
      div_done_o   = 1'b0;
      if (!rst_i) begin
         if (divStall) begin
            div_busy_o = 1'b1;
            div_done_o = (state_q == DIV) && (cnt_q == 6'd0);
         end else if (ex_branch_taken_i) begin
            pc_en_o      = 1'b1;
            ifid_en_o    = 1'b1;
            ifid_flush_o = 1'b1;
            idex_en_o    = 1'b1;
            idex_flush_o = 1'b1;
            exmem_en_o   = 1'b1;
         end else if (loadUse) begin
            idex_en_o    = 1'b1;
            idex_flush_o = 1'b1;
            exmem_en_o   = 1'b1;
         end else begin
            pc_en_o    = 1'b1;
            ifid_en_o  = 1'b1;
            idex_en_o  = 1'b1;
            exmem_en_o = 1'b1;
         end
      end
   end

   // Next-state for the divide sequencer and the saturating stall counter.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stall_d = stall_q;
      case (state_q)
         RUN: begin
            if (ex_div_start_i) begin
               state_d = DIV;
               cnt_d   = DIV_LOAD;
            end
         end
         DIV: begin
            if (cnt_q == 6'd0) begin
               state_d = RUN;
            end else begin
               cnt_d = cnt_q - 6'd1;
            end
         end
         default: state_d = RUN;
      endcase
      if (!pc_en_o && (stall_q != 32'hFFFF_FFFF)) begin
         stall_d = stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= RUN;
         cnt_q   <= 6'd0;
         stall_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         stall_q <= stall_d;
      end
   end

   assign stall_cycles_o = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: load-use, branch flush, divide stall,
// reset abort and stall-counter saturation, checked with immediate assertions.
module tb_pipe_hazard_ctrl;

   logic        clk;
   logic        rst;
   logic [4:0]  idRs, idRt, exRt;
   logic        exMemread, exBranch, exDivStart;
   logic        pcEn, ifidEn, ifidFlush, idexEn, idexFlush, exmemEn, divBusy, divDone;
   logic [31:0] stallCycles;

   int checks   = 0;
   int failures = 0;

   // Output bundle order: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, div_busy, div_done}
   localparam logic [7:0] OUT_RST  = 8'b0000_0000;
   localparam logic [7:0] OUT_NORM = 8'b1101_0100;
   localparam logic [7:0] OUT_BR   = 8'b1111_1100;
   localparam logic [7:0] OUT_LU   = 8'b0001_1100;
   localparam logic [7:0] OUT_DIV  = 8'b0000_0010;
   localparam logic [7:0] OUT_DONE = 8'b0000_0011;

   pipe_hazard_ctrl #(.DIV_CYCLES(32)) dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .id_rs_addr_i      (idRs),
      .id_rt_addr_i      (idRt),
      .ex_memread_i      (exMemread),
      .ex_rt_addr_i      (exRt),
      .ex_branch_taken_i (exBranch),
      .ex_div_start_i    (exDivStart),
      .pc_en_o           (pcEn),
      .ifid_en_o         (ifidEn),
      .ifid_flush_o      (ifidFlush),
      .idex_en_o         (idexEn),
      .idex_flush_o      (idexFlush),
      .exmem_en_o        (exmemEn),
      .div_busy_o        (divBusy),
      .div_done_o        (divDone),
      .stall_cycles_o    (stallCycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic mr,
                                input logic [4:0] er, input logic br, input logic ds);
      idRs = rs; idRt = rt; exMemread = mr; exRt = er; exBranch = br; exDivStart = ds;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] expected);
      logic [7:0] observed;
      observed = {pcEn, ifidEn, ifidFlush, idexEn, idexFlush, exmemEn, divBusy, divDone};
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
      end
   endtask

   task automatic checkCount(input string tag, input logic [31:0] expected);
      checks++;
      assert (stallCycles === expected) else begin
         failures++;
         $error("[TB] FAIL %s stall_cycles observed=%h expected=%h", tag, stallCycles, expected);
      end
   endtask

   // Linear directed sequence; inputs change 1ns after each rising edge.
   initial begin
      rst = 1'b1;
      applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      tick();
      tick();
      checkOutput("reset_outputs", OUT_RST);
      checkCount("reset_count", 32'd0);

      rst = 1'b0;
      applyStimulus(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
      checkOutput("normal", OUT_NORM);
      tick();
      checkCount("normal_count", 32'd0);

      applyStimulus(5'd8, 5'd0, 1'b1, 5'd8, 1'b0, 1'b0);
      checkOutput("loaduse_rs", OUT_LU);
      tick();
      applyStimulus(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
      checkOutput("after_loaduse", OUT_NORM);
      checkCount("loaduse_count", 32'd1);

      applyStimulus(5'd3, 5'd8, 1'b1, 5'd8, 1'b0, 1'b0);
      checkOutput("loaduse_rt", OUT_LU);
      tick();
      checkCount("loaduse_rt_count", 32'd2);

      applyStimulus(5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
      checkOutput("loaduse_r0", OUT_NORM);
      applyStimulus(5'd8, 5'd8, 1'b0, 5'd8, 1'b0, 1'b0);
      checkOutput("no_memread", OUT_NORM);
      tick();
      checkCount("no_stall_count", 32'd2);

      applyStimulus(5'd8, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0);
      checkOutput("branch_over_loaduse", OUT_BR);
      tick();
      checkCount("branch_count", 32'd2);
      applyStimulus(5'd4, 5'd5, 1'b0, 5'd0, 1'b1, 1'b0);
      checkOutput("branch_only", OUT_BR);
      tick();

      // Divide starting at T: stall T..T+31, done at T+31, normal at T+32.
      applyStimulus(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1);
      checkOutput("div_start", OUT_DIV);
      tick();
      for (int i = 1; i < 32; i++) begin
         if (i == 5) applyStimulus(5'd8, 5'd0, 1'b1, 5'd8, 1'b1, 1'b1);
         else        applyStimulus(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
         checkOutput((i == 31) ? "div_done" : "div_busy", (i == 31) ? OUT_DONE : OUT_DIV);
         if (i == 16) checkCount("div_mid_count", 32'd18);
         tick();
      end
      applyStimulus(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
      checkOutput("div_exit", OUT_NORM);
      checkCount("div_count", 32'd34);
      tick();

      // Reset ten cycles into a divide aborts it.
      applyStimulus(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1);
      tick();
      applyStimulus(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
      for (int i = 1; i < 10; i++) tick();
      checkOutput("div_before_rst", OUT_DIV);
      rst = 1'b1;
      #1;
      checkOutput("rst_in_div", OUT_RST);
      tick();
      checkOutput("rst_held", OUT_RST);
      tick();
      rst = 1'b0;
      #1;
      checkOutput("after_rst_run", OUT_NORM);
      checkCount("after_rst_count", 32'd0);
      tick();
      checkOutput("after_rst_still_run", OUT_NORM);
      checkCount("after_rst_count2", 32'd0);

      // Saturation of the stall counter.
      force dut.stall_q = 32'hFFFF_FFFE;
      #1;
      release dut.stall_q;
      applyStimulus(5'd8, 5'd0, 1'b1, 5'd8, 1'b0, 1'b0);
      checkCount("sat_preset", 32'hFFFF_FFFE);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkCount("sat_hold", 32'hFFFF_FFFF);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
